gate_bist_ctrl: RTL
===================

# gate_bist_ctrl

Built-in self-test sequencer for a small combinational gate under test (GUT), such as the two-input CMOS NAND cell. On a start request it drives every input pattern to the GUT in binary order. It waits a programmable settle time per pattern, samples the GUT output, and compares it with the expected truth-table value for a selected gate function. It reports pass/fail, the mismatch count and the first failing pattern, so gate models can be checked in simulation without hand-written stimulus.

## Interface
Parameters:
- N_IN, 2, number of GUT inputs; patterns 0 .. 2^N_IN-1.
- SETTLE, 2, cycles each pattern is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- abort  input  1  cancels a run; priority over start.
- func  input  2  expected function, latched on start accept:
  - 00: NAND
  - 01: NOR
  - 10: AND
  - 11: OR
- gut_f  input  1  GUT output.
- gut_in  output  N_IN  registered pattern driven to GUT inputs; bit 0 is the LSB of the pattern.
- busy  output  1  high in WAIT and CHECK.
- done  output  1  high while in DONE.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching patterns; no saturation needed (max 2^N_IN).
- fail_pat  output  N_IN  first mismatching pattern; meaningful only when err_count != 0.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- Reset (clrn=0, immediate, no clock needed): state IDLE, gut_in=0, busy=0, done=0, pass=0, err_count=0, fail_pat=0, settle counter=0, latched func=00.
- IDLE / DONE, on start=1 and abort=0:
  - latch func; gut_in<=0; err_count<=0; fail_pat<=0; counter<=0; done<=0; pass<=0.
  - go to WAIT.
- WAIT: counter increments each cycle; after SETTLE cycles in WAIT, go to CHECK.
- CHECK: compute the expected value from gut_in and the latched func:
  - NAND: expected = ~&gut_in
  - NOR: expected = ~|gut_in
  - AND: expected = &gut_in
  - OR: expected = |gut_in
- CHECK, on mismatch (gut_f != expected): err_count increments. If err_count was 0, fail_pat<=gut_in.
- CHECK, when gut_in != all-ones: gut_in<=gut_in+1; counter<=0; go to WAIT.
- CHECK, when gut_in == all-ones: go to DONE; gut_in<=0; done<=1; pass<=1 iff no mismatch (including this one).
- DONE: outputs held until start or abort.
- abort=1 in WAIT, CHECK or DONE: next edge goes to IDLE with all outputs at their reset values. abort in IDLE has no effect.
- start=1 in WAIT or CHECK is ignored; the run continues unchanged.
- gut_f is sampled only in the CHECK cycle; its value in other cycles is irrelevant.

## Timing
- Each pattern occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK.
- The start-accept edge is E0.
- DONE is entered at edge E0 + 2^N_IN*(SETTLE+1).
- Defaults (N_IN=2, SETTLE=2):
  - busy is high for 12 cycles; done rises at E12.
  - gut_in = 00 during E0..E2, 01 during E3..E5, 10 during E6..E8, 11 during E9..E11.
- err_count updates on the edge that ends CHECK, so a mismatch is visible one cycle after the sample.
- Minimum restart: start asserted in the first DONE cycle begins a new WAIT on the next edge, and done drops on that same edge.

## Test plan
- Correct NAND model (gut_f = ~&gut_in), func=00, 1-cycle start pulse -> gut_in sequence 00/01/10/11 at 3 cycles each; done=1 at E12; pass=1; err_count=0.
- GUT stuck-at-1, func=00 -> only pattern 11 mismatches; done at E12; err_count=1; fail_pat=11; pass=0.
- Correct NAND model with func=01 (NOR expected) -> patterns 01 and 10 mismatch; err_count=2; fail_pat=01; pass=0.
- abort at E5 (pattern 01 in CHECK) -> at E6: IDLE, busy=0, gut_in=00, err_count=0. A following start runs a full 12-cycle pass.
- clrn pulled low mid-WAIT between clock edges -> all outputs zero immediately. start held high through a full run is ignored until DONE, then restarts the run and clears done on the next edge.
- SETTLE=1, N_IN=3 with a correct AND model, func=10 -> 8 patterns at 2 cycles each; done at E16; pass=1.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a small combinational gate under test.
// Walks all input patterns in binary order, holds each one for SETTLE cycles,
// samples the gate output, and compares it with the expected truth table.
module gate_bist_ctrl #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            start,
   input  logic            abort,
   input  logic [1:0]      func,
   input  logic            gut_f,
   output logic [N_IN-1:0] gut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] fail_pat
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned ERR_W = N_IN + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_WAIT  = 2'b01,
      S_CHECK = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      FN_NAND = 2'b00,
      FN_NOR  = 2'b01,
      FN_AND  = 2'b10,
      FN_OR   = 2'b11
   } func_t;

   state_t             state_q,    state_d;
   func_t              func_q,     func_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [N_IN-1:0]    gut_in_q,   gut_in_d;
   logic [N_IN-1:0]    fail_pat_q, fail_pat_d;
   logic [ERR_W-1:0]   err_q,      err_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               pass_q,     pass_d;

   logic               expected_c;
   logic               mismatch_c;

   // Expected gate output for the pattern currently driven.
   always_comb begin
      expected_c = 1'b0;
      case (func_q)
         FN_NAND: expected_c = ~(&gut_in_q);
         FN_NOR:  expected_c = ~(|gut_in_q);
         FN_AND:  expected_c = &gut_in_q;
         FN_OR:   expected_c = |gut_in_q;
         default: expected_c = 1'b0;
      endcase
   end

   assign mismatch_c = (gut_f != expected_c);

   // Next-state and next-output logic for the test sequencer.
   always_comb begin
      state_d    = state_q;
      func_d     = func_q;
      cnt_d      = cnt_q;
      gut_in_d   = gut_in_q;
      fail_pat_d = fail_pat_q;
      err_d      = err_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;

      if (abort && (state_q != S_IDLE)) begin
         // Abort returns everything to the reset picture in one edge.
         state_d    = S_IDLE;
         func_d     = FN_NAND;
         cnt_d      = '0;
         gut_in_d   = '0;
         fail_pat_d = '0;
         err_d      = '0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         pass_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && !abort) begin
                  state_d    = S_WAIT;
                  func_d     = func_t'(func);
                  cnt_d      = '0;
                  gut_in_d   = '0;
                  fail_pat_d = '0;
                  err_d      = '0;
                  busy_d     = 1'b1;
                  done_d     = 1'b0;
                  pass_d     = 1'b0;
               end
            end
            S_WAIT: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (mismatch_c) begin
                  err_d = err_q + ERR_W'(1);
                  if (err_q == '0) begin
                     fail_pat_d = gut_in_q;
                  end
               end
               if (gut_in_q != '1) begin
                  state_d  = S_WAIT;
                  gut_in_d = gut_in_q + N_IN'(1);
                  cnt_d    = '0;
               end else begin
                  state_d  = S_DONE;
                  gut_in_d = '0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  pass_d   = (err_q == '0) && !mismatch_c;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= S_IDLE;
         func_q     <= FN_NAND;
         cnt_q      <= '0;
         gut_in_q   <= '0;
         fail_pat_q <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         func_q     <= func_d;
         cnt_q      <= cnt_d;
         gut_in_q   <= gut_in_d;
         fail_pat_q <= fail_pat_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign gut_in    = gut_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_pat  = fail_pat_q;

endmodule
